lsu_conv_seq: RTL and testbench

//  Sequences one convolution command through the LSU datapath: clears the MXU, streams row reads

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_conv_seq_if.sv | 58 +++++
 rtl/lsu_rd_addr_gen.sv | 22 ++
 rtl/lsu_conv_seq.sv | 142 ++++++++++++++
 tb/tb_lsu_conv_seq.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and defaults for the LSU convolution sequencer.
// State encoding, bus width defaults and the activation/pooling selector encodings.
package lsu_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_DRAIN,
    S_WAIT,
    S_ACT,
    S_POOL,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ACT_RELU    = 2'd0,
    ACT_SIGMOID = 2'd1,
    ACT_TANH    = 2'd2,
    ACT_GELU    = 2'd3
  } act_type_e;

  typedef enum logic [1:0] {
    POOL_1X1 = 2'd0,
    POOL_2X2 = 2'd1,
    POOL_3X3 = 2'd2,
    POOL_4X4 = 2'd3
  } pool_size_e;

endpackage

// File: rtl/lsu_conv_seq_if.sv
// Command, RAM read and MXU control bundle of the convolution sequencer.
// master = command/MXU side driving the sequencer, slave = the sequencer itself.
interface lsu_conv_seq_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);

  logic              cmd_vld;
  logic              cmd_rdy;
  logic [ADDR_W-1:0] cmd_iram_base;
  logic              cmd_iram_dir;
  logic [LEN_W-1:0]  cmd_iram_rows;
  logic [ADDR_W-1:0] cmd_wram_base;
  logic              cmd_wram_dir;
  logic [LEN_W-1:0]  cmd_wram_rows;
  logic              cmd_act;
  logic [1:0]        cmd_act_type;
  logic              cmd_pool;
  logic [1:0]        cmd_pool_size;

  logic              iram_rd_vld;
  logic [ADDR_W-1:0] iram_rd_addr;
  logic              wram_rd_vld;
  logic [ADDR_W-1:0] wram_rd_addr;

  logic              mxu_clr;
  logic              mxu_feed_vld;
  logic [LEN_W-1:0]  mxu_row_idx;
  logic              mxu_act_vld;
  logic [1:0]        mxu_act_type;
  logic              mxu_pool_vld;
  logic [1:0]        mxu_pool_size;
  logic              mxu_rdy;

  logic              busy;
  logic              done;

  modport master (
    output cmd_vld, cmd_iram_base, cmd_iram_dir, cmd_iram_rows,
           cmd_wram_base, cmd_wram_dir, cmd_wram_rows,
           cmd_act, cmd_act_type, cmd_pool, cmd_pool_size, mxu_rdy,
    input  cmd_rdy, iram_rd_vld, iram_rd_addr, wram_rd_vld, wram_rd_addr,
           mxu_clr, mxu_feed_vld, mxu_row_idx, mxu_act_vld, mxu_act_type,
           mxu_pool_vld, mxu_pool_size, busy, done
  );

  modport slave (
    input  cmd_vld, cmd_iram_base, cmd_iram_dir, cmd_iram_rows,
           cmd_wram_base, cmd_wram_dir, cmd_wram_rows,
           cmd_act, cmd_act_type, cmd_pool, cmd_pool_size, mxu_rdy,
    output cmd_rdy, iram_rd_vld, iram_rd_addr, wram_rd_vld, wram_rd_addr,
           mxu_clr, mxu_feed_vld, mxu_row_idx, mxu_act_vld, mxu_act_type,
           mxu_pool_vld, mxu_pool_size, busy, done
  );

endinterface

// File: rtl/lsu_rd_addr_gen.sv
// Per-RAM row address generator: read enable and base +/- row index, modulo 2^ADDR_W.
// Purely combinational; the address is forced to zero whenever no read is issued.
module lsu_rd_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_dir,
  input  logic [LEN_W-1:0]  i_rows,
  input  logic [LEN_W-1:0]  i_idx,
  output logic              o_rd_vld,
  output logic [ADDR_W-1:0] o_rd_addr
);

  logic [ADDR_W-1:0] w_ofs;

  assign w_ofs     = ADDR_W'(i_idx);
  assign o_rd_vld  = i_en && (i_idx <= i_rows);
  assign o_rd_addr = o_rd_vld ? (i_dir ? i_base + w_ofs : i_base - w_ofs) : '0;

endmodule

// File: rtl/lsu_conv_seq.sv
// Sequences one conv command: MXU clear, row reads from IRAM/WRAM, drain, optional act/pool, done.
// One command at a time; cmd_rdy only in IDLE, so commands arriving while busy stall upstream.
module lsu_conv_seq
  import lsu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  lsu_conv_seq_if.slave bus
);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_iram_base;
  logic              r_iram_dir;
  logic [LEN_W-1:0]  r_iram_rows;
  logic [ADDR_W-1:0] r_wram_base;
  logic              r_wram_dir;
  logic [LEN_W-1:0]  r_wram_rows;
  logic              r_act;
  act_type_e         r_act_type;
  logic              r_pool;
  pool_size_e        r_pool_size;

  logic [LEN_W-1:0]  r_cnt;
  logic [2:0]        r_dcnt;
  logic [LEN_W-1:0]  w_last;
  logic              w_beat;

  logic [RD_LAT-1:0] r_dly_vld;
  logic [LEN_W-1:0]  r_dly_idx [RD_LAT];

  assign w_last = (r_iram_rows > r_wram_rows) ? r_iram_rows : r_wram_rows;
  assign w_beat = (r_state == S_FEED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.cmd_vld) w_state_nxt = S_CLR;
      S_CLR:   w_state_nxt = S_FEED;
      S_FEED:  if (r_cnt == w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_dcnt == 3'(RD_LAT - 1)) w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.mxu_rdy) w_state_nxt = r_act ? S_ACT : (r_pool ? S_POOL : S_DONE);
      S_ACT:   if (bus.mxu_rdy) w_state_nxt = r_pool ? S_POOL : S_DONE;
      S_POOL:  if (bus.mxu_rdy) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iram_base <= '0;
      r_iram_dir  <= 1'b0;
      r_iram_rows <= '0;
      r_wram_base <= '0;
      r_wram_dir  <= 1'b0;
      r_wram_rows <= '0;
      r_act       <= 1'b0;
      r_act_type  <= ACT_RELU;
      r_pool      <= 1'b0;
      r_pool_size <= POOL_1X1;
    end else if (r_state == S_IDLE && bus.cmd_vld) begin
      r_iram_base <= bus.cmd_iram_base;
      r_iram_dir  <= bus.cmd_iram_dir;
      r_iram_rows <= bus.cmd_iram_rows;
      r_wram_base <= bus.cmd_wram_base;
      r_wram_dir  <= bus.cmd_wram_dir;
      r_wram_rows <= bus.cmd_wram_rows;
      r_act       <= bus.cmd_act;
      r_act_type  <= act_type_e'(bus.cmd_act_type);
      r_pool      <= bus.cmd_pool;
      r_pool_size <= pool_size_e'(bus.cmd_pool_size);
    end
  end

  // Row counter only runs in FEED, drain counter only in DRAIN; both idle at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_dcnt <= '0;
    end else begin
      r_cnt  <= (r_state == S_FEED)  ? r_cnt + 1'b1  : '0;
      r_dcnt <= (r_state == S_DRAIN) ? r_dcnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dly_vld <= '0;
      for (int k = 0; k < RD_LAT; k++) r_dly_idx[k] <= '0;
    end else begin
      r_dly_vld[0] <= w_beat;
      r_dly_idx[0] <= w_beat ? r_cnt : '0;
      for (int k = 1; k < RD_LAT; k++) begin
        r_dly_vld[k] <= r_dly_vld[k-1];
        r_dly_idx[k] <= r_dly_idx[k-1];
      end
    end
  end

  lsu_rd_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_iram_gen (
    .i_en      (w_beat),
    .i_base    (r_iram_base),
    .i_dir     (r_iram_dir),
    .i_rows    (r_iram_rows),
    .i_idx     (r_cnt),
    .o_rd_vld  (bus.iram_rd_vld),
    .o_rd_addr (bus.iram_rd_addr)
  );

  lsu_rd_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wram_gen (
    .i_en      (w_beat),
    .i_base    (r_wram_base),
    .i_dir     (r_wram_dir),
    .i_rows    (r_wram_rows),
    .i_idx     (r_cnt),
    .o_rd_vld  (bus.wram_rd_vld),
    .o_rd_addr (bus.wram_rd_addr)
  );

  assign bus.cmd_rdy       = (r_state == S_IDLE);
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = (r_state == S_DONE);
  assign bus.mxu_clr       = (r_state == S_CLR);
  assign bus.mxu_feed_vld  = r_dly_vld[RD_LAT-1];
  assign bus.mxu_row_idx   = r_dly_idx[RD_LAT-1];
  assign bus.mxu_act_vld   = (r_state == S_ACT);
  assign bus.mxu_act_type  = r_act_type;
  assign bus.mxu_pool_vld  = (r_state == S_POOL);
  assign bus.mxu_pool_size = r_pool_size;

endmodule

// File: tb/tb_lsu_conv_seq.sv
// Directed and randomized commands checked against a cycle-accurate expectation derived from
// the command fields and the MXU-ready pattern; all timing is relative to the accept cycle.
module tb_lsu_conv_seq;
  import lsu_pkg::*;

  localparam int L = RD_LAT_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_conv_seq_if #(.ADDR_W(8), .LEN_W(4)) bus ();

  lsu_conv_seq #(.ADDR_W(8), .LEN_W(4), .RD_LAT(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int ib; bit id; int ir;
    int wb; bit wd; int wr;
    bit act; int at; bit pool; int ps;
  } cmd_t;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  bit pat [512];
  int ird_k[$], ird_a[$], wrd_k[$], wrd_a[$];
  int feed_k[$], feed_i[$], clr_k[$], act_k[$], pool_k[$];
  int bad_busy, bad_type;
  int last_acc_abs, last_done_abs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ea(int base, bit dir, int j);
    return dir ? ((base + j) & 255) : ((base - j) & 255);
  endfunction

  function automatic cmd_t mk(int ib, bit id, int ir, int wb, bit wd, int wr,
                              bit act, int at, bit pool, int ps);
    cmd_t c;
    c.ib = ib; c.id = id; c.ir = ir;
    c.wb = wb; c.wd = wd; c.wr = wr;
    c.act = act; c.at = at; c.pool = pool; c.ps = ps;
    return c;
  endfunction

  task automatic set_pat(input bit rnd);
    for (int k = 0; k < 512; k++)
      pat[k] = (!rnd || k >= 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  task automatic summary_and_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "accept timeout");
  endtask

  // Present a command and wait (bounded) until it is seen accepted; returns the accept cycle.
  task automatic issue(input cmd_t c, output int t);
    bus.cmd_iram_base = 8'(c.ib);
    bus.cmd_iram_dir  = c.id;
    bus.cmd_iram_rows = 4'(c.ir);
    bus.cmd_wram_base = 8'(c.wb);
    bus.cmd_wram_dir  = c.wd;
    bus.cmd_wram_rows = 4'(c.wr);
    bus.cmd_act       = c.act;
    bus.cmd_act_type  = 2'(c.at);
    bus.cmd_pool      = c.pool;
    bus.cmd_pool_size = 2'(c.ps);
    bus.cmd_vld       = 1'b1;
    t = -1;
    for (int n = 0; n < 300; n++) begin
      if (bus.cmd_rdy) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) begin
      chk("accept_timeout", 32'(t), 32'(0));
      summary_and_stop();
    end
  endtask

  task automatic run_cmd(input cmd_t c, input bit keep_vld);
    int t, d, nb, tw, x, a0, a1, p0, p1, dexp;
    ird_k.delete(); ird_a.delete(); wrd_k.delete(); wrd_a.delete();
    feed_k.delete(); feed_i.delete(); clr_k.delete(); act_k.delete(); pool_k.delete();
    bad_busy = 0;
    bad_type = 0;
    issue(c, t);
    last_acc_abs = t;
    d = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1 && !keep_vld) bus.cmd_vld = 1'b0;
      if (bus.iram_rd_vld) begin ird_k.push_back(k); ird_a.push_back(int'(bus.iram_rd_addr)); end
      if (bus.wram_rd_vld) begin wrd_k.push_back(k); wrd_a.push_back(int'(bus.wram_rd_addr)); end
      if (bus.mxu_feed_vld) begin feed_k.push_back(k); feed_i.push_back(int'(bus.mxu_row_idx)); end
      if (bus.mxu_clr) clr_k.push_back(k);
      if (bus.mxu_act_vld) begin
        act_k.push_back(k);
        if (int'(bus.mxu_act_type) != c.at) bad_type++;
      end
      if (bus.mxu_pool_vld) begin
        pool_k.push_back(k);
        if (int'(bus.mxu_pool_size) != c.ps) bad_type++;
      end
      if (bus.cmd_rdy || !bus.busy) bad_busy++;
      bus.mxu_rdy = pat[k];
      if (bus.done) begin
        d = k;
        break;
      end
    end
    last_done_abs = t + d;

    // Reference: feed occupies cycles 2..N+1, drain L cycles, then each MXU step ends on the
    // first cycle at/after its start where mxu_rdy is high.
    nb = ((c.ir > c.wr) ? c.ir : c.wr) + 1;
    tw = 2 + nb + L;
    x = tw;
    while (x < 511 && !pat[x]) x++;
    a0 = -1; a1 = -1; p0 = -1; p1 = -1;
    if (c.act) begin
      a0 = x + 1; x = a0;
      while (x < 511 && !pat[x]) x++;
      a1 = x;
    end
    if (c.pool) begin
      p0 = x + 1; x = p0;
      while (x < 511 && !pat[x]) x++;
      p1 = x;
    end
    dexp = x + 1;

    chk("done_cyc", 32'(d), 32'(dexp));
    chk("clr_n", 32'(clr_k.size()), 32'(1));
    if (clr_k.size() > 0) chk("clr_cyc", 32'(clr_k[0]), 32'(1));
    chk("ird_n", 32'(ird_k.size()), 32'(c.ir + 1));
    for (int j = 0; j < ird_k.size() && j <= c.ir; j++) begin
      chk("ird_cyc", 32'(ird_k[j]), 32'(2 + j));
      chk("ird_addr", 32'(ird_a[j]), 32'(ea(c.ib, c.id, j)));
    end
    chk("wrd_n", 32'(wrd_k.size()), 32'(c.wr + 1));
    for (int j = 0; j < wrd_k.size() && j <= c.wr; j++) begin
      chk("wrd_cyc", 32'(wrd_k[j]), 32'(2 + j));
      chk("wrd_addr", 32'(wrd_a[j]), 32'(ea(c.wb, c.wd, j)));
    end
    chk("feed_n", 32'(feed_k.size()), 32'(nb));
    for (int j = 0; j < feed_k.size() && j < nb; j++) begin
      chk("feed_cyc", 32'(feed_k[j]), 32'(2 + j + L));
      chk("feed_idx", 32'(feed_i[j]), 32'(j));
    end
    chk("act_n", 32'(act_k.size()), 32'(c.act ? a1 - a0 + 1 : 0));
    if (c.act && act_k.size() > 0) chk("act_first", 32'(act_k[0]), 32'(a0));
    chk("pool_n", 32'(pool_k.size()), 32'(c.pool ? p1 - p0 + 1 : 0));
    if (c.pool && pool_k.size() > 0) chk("pool_first", 32'(pool_k[0]), 32'(p0));
    chk("act_pool_sel", 32'(bad_type), 32'(0));
    chk("rdy_while_busy", 32'(bad_busy), 32'(0));

    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'(0));
    chk("rdy_after_done", 32'(bus.cmd_rdy), 32'(1));
  endtask

  initial begin
    cmd_t c;
    int t, tw, d1, stray;

    bus.cmd_vld = 1'b0;
    bus.cmd_iram_base = '0; bus.cmd_iram_dir = 1'b0; bus.cmd_iram_rows = '0;
    bus.cmd_wram_base = '0; bus.cmd_wram_dir = 1'b0; bus.cmd_wram_rows = '0;
    bus.cmd_act = 1'b0; bus.cmd_act_type = '0; bus.cmd_pool = 1'b0; bus.cmd_pool_size = '0;
    bus.mxu_rdy = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'(1));
    chk("rst_ctrl", 32'({bus.iram_rd_vld, bus.wram_rd_vld, bus.mxu_clr, bus.mxu_feed_vld,
                         bus.mxu_act_vld, bus.mxu_pool_vld, bus.busy, bus.done}), 32'(0));
    chk("rst_data", 32'({bus.iram_rd_addr, bus.wram_rd_addr, bus.mxu_row_idx,
                         bus.mxu_act_type, bus.mxu_pool_size}), 32'(0));

    // T1: equal row counts, incrementing addresses
    set_pat(1'b0);
    run_cmd(mk('h10, 1, 3, 'h20, 1, 3, 0, 0, 0, 0), 1'b0);

    // T2: IRAM shorter than WRAM
    run_cmd(mk('h05, 1, 1, 'h40, 1, 5, 0, 0, 0, 0), 1'b0);

    // T3: decrementing wrap through 0x00
    run_cmd(mk('h01, 0, 3, 'h80, 0, 0, 0, 0, 0, 0), 1'b0);

    // T4: MXU busy in WAIT, then stalls during ACT and POOL
    set_pat(1'b0);
    tw = 2 + 3 + L;
    for (int k = tw; k < tw + 5; k++) pat[k] = 1'b0;
    pat[tw + 6] = 1'b0;
    pat[tw + 7] = 1'b0;
    pat[tw + 9] = 1'b0;
    run_cmd(mk('h60, 1, 2, 'h70, 0, 2, 1, 2, 1, 1), 1'b0);

    // T5: cmd_vld held through the first command; the second is taken right after done
    set_pat(1'b0);
    c = mk('h33, 1, 2, 'h44, 1, 4, 1, 3, 0, 0);
    run_cmd(c, 1'b1);
    d1 = last_done_abs;
    run_cmd(c, 1'b0);
    chk("b2b_accept", 32'(last_acc_abs), 32'(d1 + 1));

    // T6: async reset during FEED beat 2
    set_pat(1'b0);
    bus.mxu_rdy = 1'b1;
    issue(mk('h30, 1, 5, 'h50, 0, 5, 1, 1, 1, 2), t);
    @(negedge clk);
    bus.cmd_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_beat2_addr", 32'(bus.iram_rd_addr), 32'('h32));
    rst = 1'b1;
    #1;
    chk("t6_rst_cmd_rdy", 32'(bus.cmd_rdy), 32'(1));
    chk("t6_rst_ctrl", 32'({bus.iram_rd_vld, bus.wram_rd_vld, bus.mxu_clr, bus.mxu_feed_vld,
                            bus.mxu_act_vld, bus.mxu_pool_vld, bus.busy, bus.done}), 32'(0));
    chk("t6_rst_data", 32'({bus.iram_rd_addr, bus.wram_rd_addr, bus.mxu_row_idx,
                            bus.mxu_act_type, bus.mxu_pool_size}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < L + 6; k++) begin
      @(negedge clk);
      if (bus.mxu_feed_vld || bus.done || bus.mxu_clr || bus.iram_rd_vld || bus.wram_rd_vld ||
          bus.mxu_act_vld || bus.mxu_pool_vld || !bus.cmd_rdy) stray++;
    end
    chk("t6_no_stray", 32'(stray), 32'(0));
    run_cmd(mk('hFE, 1, 4, 'h02, 0, 1, 0, 0, 1, 3), 1'b0);

    // Randomized commands with random MXU-ready patterns
    for (int n = 0; n < 12; n++) begin
      set_pat(1'b1);
      run_cmd(mk($urandom_range(0, 255), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                 $urandom_range(0, 255), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
